// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//    Pops scan-code-set-2 bytes from a PS/2 receiver FIFO and tracks the
//    most recent key press. It decodes the E0/F0 prefixes, follows the shift
//    and caps-lock modifiers, suppresses typematic repeats, counts new presses
//    and keeps a short history of pressed keys.
//
// Ports
//    clk, rst          : clock; synchronous active-high reset
//    ps2_byte/ready    : receiver FIFO head byte / FIFO non-empty
//    nextdata_n        : active-low pop strobe, low for the cycle a byte is taken
//    key_valid         : the tracked key is still held down
//    key_code/key_ext  : scan code of the last accepted make and its E0 flag
//    ascii             : character of key_code with case applied (0x00 if none)
//    shift_held        : left or right shift is down
//    caps_lock         : caps-lock toggle state
//    press_cnt         : number of new non-modifier presses
//    event_valid/break : one-cycle key event pulse; break=1 marks a release
//    hist_rd_idx/data  : history read port, index 0 = newest, data = {ext, code}
//    hist_count        : number of valid history entries
module ps2_key_tracker #(
   parameter int CNT_W      = 8,
   parameter int HIST_DEPTH = 4,
   parameter int CNT_SAT    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    ps2_byte,
   input  logic                          ps2_ready,
   output logic                          nextdata_n,
   output logic                          key_valid,
   output logic [7:0]                    key_code,
   output logic                          key_ext,
   output logic [7:0]                    ascii,
   output logic                          shift_held,
   output logic                          caps_lock,
   output logic [CNT_W-1:0]              press_cnt,
   output logic                          event_valid,
   output logic                          event_break,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
   output logic [8:0]                    hist_rd_data,
   output logic [$clog2(HIST_DEPTH):0]   hist_count
);

   localparam int HW = $clog2(HIST_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

   state_t             state_reg, state_next;
   logic               pop_ok_reg;   // nextdata_n was high in the previous cycle
   logic               pop;
   logic               code_done, code_brk, code_ext;
   logic               is_lshift, is_rshift, is_caps, is_mod, same_key;
   logic               do_make, do_break;
   logic               key_valid_reg, key_ext_reg, event_valid_reg, event_break_reg;
   logic [7:0]         key_code_reg;
   logic               lshift_reg, rshift_reg, caps_lock_reg, caps_held_reg;
   logic [CNT_W-1:0]   press_cnt_reg, cnt_next;
   logic [8:0]         hist_mem [HIST_DEPTH];
   logic [HW-1:0]      hist_wr_ptr_reg, hist_rd_addr;
   logic [HW:0]        hist_count_reg;
   logic [8:0]         lut;

   // Pop is combinational so the byte is taken in the same cycle the strobe
   // is low; gating with rst keeps a byte presented during reset in the FIFO.
   assign pop        = ps2_ready & pop_ok_reg & ~rst;
   assign nextdata_n = ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         pop_ok_reg <= 1'b1;
      end else begin
         state_reg  <= state_next;
         pop_ok_reg <= ~pop;
      end
   end

   // Prefix decoder: E0/F0 only move the state; any other byte completes a code.
   always_comb begin
      state_next = state_reg;
      code_done  = 1'b0;
      code_brk   = 1'b0;
      code_ext   = 1'b0;
      if (pop) begin
         if (ps2_byte == 8'hE0) begin
            if (state_reg == ST_IDLE)
               state_next = ST_EXT;
         end else if (ps2_byte == 8'hF0 && state_reg == ST_IDLE) begin
            state_next = ST_BRK;
         end else if (ps2_byte == 8'hF0 && state_reg == ST_EXT) begin
            state_next = ST_EXT_BRK;
         end else begin
            code_done  = 1'b1;
            code_brk   = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
            code_ext   = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
            state_next = ST_IDLE;
         end
      end
   end

   assign is_lshift = code_done & ~code_ext & (ps2_byte == 8'h12);
   assign is_rshift = code_done & ~code_ext & (ps2_byte == 8'h59);
   assign is_caps   = code_done & ~code_ext & (ps2_byte == 8'h58);
   assign is_mod    = is_lshift | is_rshift | is_caps;
   assign same_key  = key_valid_reg & (code_ext == key_ext_reg) & (ps2_byte == key_code_reg);
   assign do_make   = code_done & ~code_brk & ~is_mod & ~same_key;
   assign do_break  = code_done &  code_brk & ~is_mod &  same_key;

   assign cnt_next = (CNT_SAT != 0 && press_cnt_reg == '1) ? press_cnt_reg
                                                           : press_cnt_reg + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         key_valid_reg   <= 1'b0;
         key_code_reg    <= 8'h00;
         key_ext_reg     <= 1'b0;
         lshift_reg      <= 1'b0;
         rshift_reg      <= 1'b0;
         caps_lock_reg   <= 1'b0;
         caps_held_reg   <= 1'b0;
         press_cnt_reg   <= '0;
         event_valid_reg <= 1'b0;
         event_break_reg <= 1'b0;
         hist_wr_ptr_reg <= '0;
         hist_count_reg  <= '0;
      end else begin
         event_valid_reg <= 1'b0;
         event_break_reg <= 1'b0;
         if (is_lshift)
            lshift_reg <= ~code_brk;
         if (is_rshift)
            rshift_reg <= ~code_brk;
         // Caps toggles only on the first make; typematic makes while held are ignored.
         if (is_caps) begin
            if (!code_brk) begin
               if (!caps_held_reg)
                  caps_lock_reg <= ~caps_lock_reg;
               caps_held_reg <= 1'b1;
            end else begin
               caps_held_reg <= 1'b0;
            end
         end
         if (do_make) begin
            key_valid_reg   <= 1'b1;
            key_code_reg    <= ps2_byte;
            key_ext_reg     <= code_ext;
            press_cnt_reg   <= cnt_next;
            event_valid_reg <= 1'b1;
            hist_wr_ptr_reg <= hist_wr_ptr_reg + HW'(1);
            if (hist_count_reg != (HW+1)'(HIST_DEPTH))
               hist_count_reg <= hist_count_reg + (HW+1)'(1);
         end
         if (do_break) begin
            key_valid_reg   <= 1'b0;
            event_valid_reg <= 1'b1;
            event_break_reg <= 1'b1;
         end
      end
   end

   // History storage is not reset; hist_count alone decides what is readable.
   always_ff @(posedge clk) begin
      if (do_make)
         hist_mem[hist_wr_ptr_reg] <= {code_ext, ps2_byte};
   end

   assign hist_rd_addr = hist_wr_ptr_reg - HW'(1) - hist_rd_idx;
   assign hist_rd_data = ({1'b0, hist_rd_idx} < hist_count_reg) ? hist_mem[hist_rd_addr] : 9'h000;

   // Returns {is_letter, lowercase/unshifted character}; 0 for unmapped codes.
   function automatic logic [8:0] sc2_lookup(input logic [7:0] sc);
      logic [8:0] r;
      r = 9'h000;
      case (sc)
         8'h1C: r = {1'b1, 8'h61};  8'h32: r = {1'b1, 8'h62};  8'h21: r = {1'b1, 8'h63};
         8'h23: r = {1'b1, 8'h64};  8'h24: r = {1'b1, 8'h65};  8'h2B: r = {1'b1, 8'h66};
         8'h34: r = {1'b1, 8'h67};  8'h33: r = {1'b1, 8'h68};  8'h43: r = {1'b1, 8'h69};
         8'h3B: r = {1'b1, 8'h6A};  8'h42: r = {1'b1, 8'h6B};  8'h4B: r = {1'b1, 8'h6C};
         8'h3A: r = {1'b1, 8'h6D};  8'h31: r = {1'b1, 8'h6E};  8'h44: r = {1'b1, 8'h6F};
         8'h4D: r = {1'b1, 8'h70};  8'h15: r = {1'b1, 8'h71};  8'h2D: r = {1'b1, 8'h72};
         8'h1B: r = {1'b1, 8'h73};  8'h2C: r = {1'b1, 8'h74};  8'h3C: r = {1'b1, 8'h75};
         8'h2A: r = {1'b1, 8'h76};  8'h1D: r = {1'b1, 8'h77};  8'h22: r = {1'b1, 8'h78};
         8'h35: r = {1'b1, 8'h79};  8'h1A: r = {1'b1, 8'h7A};
         8'h45: r = {1'b0, 8'h30};  8'h16: r = {1'b0, 8'h31};  8'h1E: r = {1'b0, 8'h32};
         8'h26: r = {1'b0, 8'h33};  8'h25: r = {1'b0, 8'h34};  8'h2E: r = {1'b0, 8'h35};
         8'h36: r = {1'b0, 8'h36};  8'h3D: r = {1'b0, 8'h37};  8'h3E: r = {1'b0, 8'h38};
         8'h46: r = {1'b0, 8'h39};
         8'h29: r = {1'b0, 8'h20};  8'h5A: r = {1'b0, 8'h0D};  8'h66: r = {1'b0, 8'h08};
         8'h0D: r = {1'b0, 8'h09};  8'h76: r = {1'b0, 8'h1B};  8'h4E: r = {1'b0, 8'h2D};
         8'h55: r = {1'b0, 8'h3D};  8'h41: r = {1'b0, 8'h2C};  8'h49: r = {1'b0, 8'h2E};
         8'h4A: r = {1'b0, 8'h2F};  8'h4C: r = {1'b0, 8'h3B};  8'h52: r = {1'b0, 8'h27};
         8'h54: r = {1'b0, 8'h5B};  8'h5B: r = {1'b0, 8'h5D};  8'h5D: r = {1'b0, 8'h5C};
         8'h0E: r = {1'b0, 8'h60};
         default: r = 9'h000;
      endcase
      return r;
   endfunction

   assign lut = sc2_lookup(key_code_reg);

   always_comb begin
      ascii = 8'h00;
      if (!key_ext_reg)
         ascii = (lut[8] && (shift_held ^ caps_lock_reg)) ? lut[7:0] - 8'h20 : lut[7:0];
   end

   assign key_valid   = key_valid_reg;
   assign key_code    = key_code_reg;
   assign key_ext     = key_ext_reg;
   assign shift_held  = lshift_reg | rshift_reg;
   assign caps_lock   = caps_lock_reg;
   assign press_cnt   = press_cnt_reg;
   assign event_valid = event_valid_reg;
   assign event_break = event_break_reg;
   assign hist_count  = hist_count_reg;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: a queue models the receiver FIFO, a behavioural
// key model pushes expected events to a scoreboard as bytes are queued, and a
// monitor pops and compares them whenever the DUT pulses event_valid. A second
// instance with a saturating counter runs on the same stimulus.
`timescale 1ns/1ps
module tb_ps2_key_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ps2_byte = 8'h00;
   logic       ps2_ready = 1'b0;
   logic [1:0] hist_rd_idx = 2'd0;

   logic       nextdata_n, key_valid, key_ext, shift_held, caps_lock, event_valid, event_break;
   logic [7:0] key_code, ascii, press_cnt;
   logic [8:0] hist_rd_data;
   logic [2:0] hist_count;

   logic       nextdata_n_s, key_valid_s, key_ext_s, shift_held_s, caps_lock_s, event_valid_s, event_break_s;
   logic [7:0] key_code_s, ascii_s, press_cnt_s;
   logic [8:0] hist_rd_data_s;
   logic [2:0] hist_count_s;

   ps2_key_tracker #(.CNT_W(8), .HIST_DEPTH(4), .CNT_SAT(0)) dut (
      .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_ready(ps2_ready),
      .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
      .key_ext(key_ext), .ascii(ascii), .shift_held(shift_held),
      .caps_lock(caps_lock), .press_cnt(press_cnt), .event_valid(event_valid),
      .event_break(event_break), .hist_rd_idx(hist_rd_idx),
      .hist_rd_data(hist_rd_data), .hist_count(hist_count));

   ps2_key_tracker #(.CNT_W(8), .HIST_DEPTH(4), .CNT_SAT(1)) dut_sat (
      .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_ready(ps2_ready),
      .nextdata_n(nextdata_n_s), .key_valid(key_valid_s), .key_code(key_code_s),
      .key_ext(key_ext_s), .ascii(ascii_s), .shift_held(shift_held_s),
      .caps_lock(caps_lock_s), .press_cnt(press_cnt_s), .event_valid(event_valid_s),
      .event_break(event_break_s), .hist_rd_idx(hist_rd_idx),
      .hist_rd_data(hist_rd_data_s), .hist_count(hist_count_s));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
      logic [7:0] cnt;
      logic [7:0] cnt_sat;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int         total = 0;
   int         bad = 0;
   int         dbl_low = 0;
   int         sat_diff = 0;
   logic       nd_s = 1'b1;
   logic       prev_nd = 1'b1;

   // key model state
   int         m_state, m_cnt;
   bit         m_lsh, m_rsh, m_caps, m_caps_held, m_valid, m_ext;
   logic [7:0] m_code;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0;
      m_valid = 0; m_ext = 0; m_code = 8'h00;
   endtask

   // m_state: 0 idle, 1 after E0, 2 after F0, 3 after E0 F0
   task automatic model_byte(input logic [7:0] b);
      bit   brk, ext;
      exp_t e;
      if (b == 8'hE0) begin
         if (m_state == 0) m_state = 1;
         return;
      end
      if (b == 8'hF0 && m_state <= 1) begin
         m_state = m_state + 2;
         return;
      end
      brk = (m_state >= 2);
      ext = (m_state == 1) || (m_state == 3);
      m_state = 0;
      if (!ext && (b == 8'h12 || b == 8'h59 || b == 8'h58)) begin
         if (b == 8'h12) m_lsh = !brk;
         else if (b == 8'h59) m_rsh = !brk;
         else if (!brk) begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1;
         end else m_caps_held = 0;
         return;
      end
      if (!brk) begin
         if (m_valid && m_ext == ext && m_code == b) return;
         m_valid = 1; m_ext = ext; m_code = b; m_cnt++;
         e = '{1'b0, ext, b, 8'(m_cnt), (m_cnt > 255) ? 8'hFF : 8'(m_cnt)};
         exp_q.push_back(e);
      end else if (m_valid && m_ext == ext && m_code == b) begin
         m_valid = 0;
         e = '{1'b1, ext, b, 8'(m_cnt), (m_cnt > 255) ? 8'hFF : 8'(m_cnt)};
         exp_q.push_back(e);
      end
   endtask

   task automatic send(input logic [7:0] b);
      fifo_q.push_back(b);
      model_byte(b);
   endtask

   task automatic drain();
      int n = 0;
      while (fifo_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("drain", 32'(fifo_q.size()), 0);
   endtask

   task automatic do_reset(input int cycles);
      chk("events_pending", 32'(exp_q.size()), 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // receiver FIFO: pops after an edge at which nextdata_n was low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!nd_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
         ps2_ready = (fifo_q.size() != 0);
         ps2_byte  = ps2_ready ? fifo_q[0] : 8'h00;
      end
   end

   // monitor: sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         nd_s = nextdata_n;
         if (!nextdata_n && !prev_nd) dbl_low++;
         prev_nd = nextdata_n;
         if ({nextdata_n_s, key_valid_s, key_code_s, key_ext_s, ascii_s, shift_held_s, caps_lock_s,
              event_break_s, hist_rd_data_s, hist_count_s} !==
             {nextdata_n, key_valid, key_code, key_ext, ascii, shift_held, caps_lock,
              event_break, hist_rd_data, hist_count})
            sat_diff++;
         if (event_valid || event_valid_s) begin
            chk("evt_sat_sync", event_valid_s, event_valid);
            if (exp_q.size() == 0) begin
               chk("evt_unexpected", 32'(exp_q.size()), 1);
            end else begin
               e = exp_q.pop_front();
               $display("event brk=%0d ext=%0d code=%02h cnt=%0d cnt_sat=%0d",
                        event_break, key_ext, key_code, press_cnt, press_cnt_s);
               chk("evt_break", event_break, e.brk);
               chk("evt_ext", key_ext, e.ext);
               chk("evt_code", key_code, e.code);
               chk("evt_key_valid", key_valid, !e.brk);
               chk("evt_cnt", press_cnt, e.cnt);
               chk("evt_cnt_sat", press_cnt_s, e.cnt_sat);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] cb;
      logic [8:0] hist_exp [4];

      // reset with a byte already waiting: it must stay in the FIFO
      model_reset();
      send(8'h1C);
      repeat (3) @(negedge clk);
      chk("rst_nextdata_n", nextdata_n, 1);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_key_code", key_code, 8'h00);
      chk("rst_key_ext", key_ext, 0);
      chk("rst_press_cnt", press_cnt, 0);
      chk("rst_hist_count", hist_count, 0);
      chk("rst_shift", shift_held, 0);
      chk("rst_caps", caps_lock, 0);
      chk("rst_event", event_valid, 0);
      rst = 1'b0;
      drain();
      chk("mk_key_valid", key_valid, 1);
      chk("mk_key_code", key_code, 8'h1C);
      chk("mk_ascii", ascii, 8'h61);
      chk("mk_press_cnt", press_cnt, 1);
      send(8'hF0); send(8'h1C);
      drain();
      chk("brk_key_valid", key_valid, 0);
      chk("brk_press_cnt", press_cnt, 1);
      chk("brk_ascii_kept", ascii, 8'h61);

      // typematic repeat with ready held high
      do_reset(2);
      send(8'h1C); send(8'h1C); send(8'h1C);
      drain();
      chk("rep_press_cnt", press_cnt, 1);
      chk("rep_hist_count", hist_count, 1);
      chk("rep_key_valid", key_valid, 1);

      // shift / caps-lock
      do_reset(2);
      send(8'h12); send(8'h1C);
      drain();
      chk("sh_ascii", ascii, 8'h41);
      chk("sh_shift", shift_held, 1);
      chk("sh_press_cnt", press_cnt, 1);
      send(8'h58); send(8'hF0); send(8'h58);
      drain();
      chk("caps_on", caps_lock, 1);
      chk("caps_shift_ascii", ascii, 8'h61);
      send(8'hF0); send(8'h12);
      drain();
      chk("sh_release", shift_held, 0);
      chk("caps_ascii", ascii, 8'h41);
      send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
      drain();
      chk("caps_typematic", caps_lock, 0);
      chk("caps_off_ascii", ascii, 8'h61);
      send(8'h59); send(8'h12); send(8'hF0); send(8'h12);
      drain();
      chk("rshift_still_held", shift_held, 1);
      chk("rshift_ascii", ascii, 8'h41);
      send(8'hF0); send(8'h59);
      drain();
      chk("rshift_release", shift_held, 0);

      // extended codes and prefix corner cases
      do_reset(2);
      hist_rd_idx = 2'd0; #1;
      chk("hist_empty_rd", hist_rd_data, 9'h000);
      send(8'hE0); send(8'h75);
      drain();
      chk("ext_key_ext", key_ext, 1);
      chk("ext_key_code", key_code, 8'h75);
      chk("ext_ascii", ascii, 8'h00);
      hist_rd_idx = 2'd0; #1;
      chk("ext_hist0", hist_rd_data, 9'h175);
      hist_rd_idx = 2'd1; #1;
      chk("ext_hist1_beyond", hist_rd_data, 9'h000);
      send(8'hF0); send(8'h75);
      drain();
      chk("ext_plain_break", key_valid, 1);
      send(8'hE0); send(8'hF0); send(8'h75);
      drain();
      chk("ext_break", key_valid, 0);
      send(8'hE0); send(8'hE0); send(8'h75);
      send(8'h1C); send(8'hF0); send(8'hE0); send(8'h1C);
      drain();
      chk("e0_in_brk", key_valid, 0);
      chk("e0_press_cnt", press_cnt, 3);

      // 256 presses: wrap vs saturate, then history order
      do_reset(2);
      for (int c = 0; c < 256; c++) begin
         cb = 8'(c);
         if (cb != 8'hE0 && cb != 8'hF0 && cb != 8'h12 && cb != 8'h58 && cb != 8'h59) begin
            send(cb); send(8'hF0); send(cb);
         end
      end
      for (int j = 0; j < 5; j++) begin
         cb = 8'h70 + 8'(j);
         send(8'hE0); send(cb); send(8'hE0); send(8'hF0); send(cb);
      end
      drain();
      chk("cnt_wrap", press_cnt, 8'h00);
      chk("cnt_sat", press_cnt_s, 8'hFF);
      send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
      drain();
      hist_exp[0] = 9'h02C; hist_exp[1] = 9'h02D; hist_exp[2] = 9'h024; hist_exp[3] = 9'h01D;
      for (int i = 0; i < 4; i++) begin
         hist_rd_idx = 2'(i); #1;
         chk($sformatf("hist_idx%0d", i), hist_rd_data, hist_exp[i]);
      end
      chk("hist_count_full", hist_count, 4);

      // reset discards a pending F0
      do_reset(2);
      send(8'hF0);
      drain();
      do_reset(1);
      send(8'h1C);
      drain();
      chk("rstpfx_key_valid", key_valid, 1);
      chk("rstpfx_press_cnt", press_cnt, 1);

      chk("events_left", 32'(exp_q.size()), 0);
      chk("nextdata_double_low", dbl_low, 0);
      chk("sat_instance_diff", sat_diff, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 8, press-counter width (1..16).
REQ-002 SHALL have parameter HIST_DEPTH, default 4, key-history entries (power of two, 2..16); HW = log2(HIST_DEPTH).
REQ-003 SHALL have parameter CNT_SAT, default 0; 0 = counter wraps, 1 = counter saturates at all-ones.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ps2_byte  in  8  byte presented by the keyboard receiver FIFO.
REQ-007 ps2_ready  in  1  receiver FIFO non-empty; ps2_byte valid.
REQ-008 nextdata_n  out  1  active-low pop strobe to the receiver.
REQ-009 key_valid  out  1  a tracked key is currently held.
REQ-010 key_code  out  8  scan code of last accepted make.
REQ-011 key_ext  out  1  last accepted make was E0-prefixed.
REQ-012 ascii  out  8  ASCII of key_code with case applied, 0x00 if unmapped.
REQ-013 shift_held  out  1  left (0x12) or right (0x59) shift held.
REQ-014 caps_lock  out  1  caps-lock toggle state.
REQ-015 press_cnt  out  CNT_W  count of new non-modifier makes.
REQ-016 event_valid  out  1  one-cycle pulse per key event; event_break  out  1  qualifies it (1 = release).
REQ-017 hist_rd_idx  in  HW  history read index, 0 = newest; hist_rd_data  out  9  {ext, code}, combinational read; hist_count  out  HW+1  valid entries.

Function
REQ-018 Pop handshake: when ps2_ready=1 and nextdata_n was 1 in the previous cycle, SHALL drive nextdata_n=0 for exactly one cycle and consume ps2_byte in that same cycle; never two consecutive low cycles (throughput max 1 byte / 2 cycles).
REQ-019 Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0); E0 in IDLE->EXT, F0 in IDLE->BRK, F0 in EXT->EXT_BRK; any other byte completes the code and returns to IDLE.
REQ-020 E0 received in BRK or EXT_BRK, or repeated E0 in EXT, SHALL be ignored (state unchanged).
REQ-021 Completed code in IDLE/EXT = make with ext = (state==EXT); in BRK/EXT_BRK = break with ext = (state==EXT_BRK).
REQ-022 Non-extended 0x12/0x59 make sets shift_held, break clears it when no shift remains held (track both separately); these bytes never alter key_code, counter, history or events.
REQ-023 Non-extended 0x58 make toggles caps_lock only if 0x58 not already held (typematic ignored); break clears the held flag; no event.
REQ-024 Non-modifier make equal to {key_ext,key_code} while key_valid=1 = typematic repeat: no state change, no event.
REQ-025 Other non-modifier make: key_code/key_ext updated, key_valid=1, press_cnt+1 (wrap or saturate per CNT_SAT), history push, event_valid=1, event_break=0, all on the cycle after consumption.
REQ-026 Break matching {key_ext,key_code} while key_valid=1: key_valid=0, event_valid=1, event_break=1; key_code, ascii, counter unchanged.
REQ-027 Non-matching break: no state change, no event.
REQ-028 ascii: from the team's scan-code-set-2 table; letters uppercase iff shift_held XOR caps_lock; digits and others unshifted; key_ext=1 gives 0x00; updates combinationally with shift/caps.
REQ-029 History: circular buffer, push overwrites oldest when full; hist_count saturates at HIST_DEPTH; hist_rd_idx >= hist_count reads 0x000.

Reset
REQ-030 rst=1 SHALL, on that edge, override all activity: FSM IDLE, nextdata_n=1, key_valid=0, key_code=0x00, key_ext=0, shift/caps/held flags 0, press_cnt=0, event_valid=0, event_break=0, hist_count=0; history contents need not clear.
REQ-031 A byte presented during rst SHALL not be consumed; a pending prefix is discarded.

Verification
REQ-032 Reset, bytes 1C, F0, 1C -> after 1C: key_valid=1, key_code=0x1C, ascii=0x61, press_cnt=1, one event pulse break=0; after F0 1C: key_valid=0, one event pulse break=1, press_cnt=1.
REQ-033 Bytes 1C,1C,1C -> press_cnt=1, hist_count=1, exactly one event pulse; nextdata_n never low two consecutive cycles with ps2_ready held 1.
REQ-034 Bytes 12, 1C -> ascii=0x41, shift_held=1, press_cnt=1; then 58, F0 58 -> caps_lock=1, ascii=0x61; F0 12 -> shift_held=0, ascii=0x41.
REQ-035 Bytes E0 75 -> key_ext=1, key_code=0x75, ascii=0x00; F0 75 -> key_valid stays 1, no event; E0 F0 75 -> key_valid=0, break event.
REQ-036 CNT_W=8: 256 distinct make/break pairs -> CNT_SAT=0 press_cnt=0x00, CNT_SAT=1 press_cnt=0xFF; HIST_DEPTH=4 after makes 15,1D,24,2D,2C -> hist idx0..3 = 2C,2D,24,1D, hist_count=4.
REQ-037 Byte F0, rst for one cycle, then 1C -> treated as make: key_valid=1, press_cnt=1.
